conv_psum_store: RTL and testbench

- Downstream consumer of the convolution stage's (out_pixel, valid) stream.
- Accumulates per-pixel partial sums across input channels in an internal accumulator RAM.
- On the last input channel, requantizes each sum to 8 bits and writes it to an output feature-map buffer.
- Returns the save_done handshake that advances the convolution stage to its next output pixel.

---
 rtl/conv_psum_store_if.sv | 14 +
 rtl/conv_psum_store.sv | 118 +++++++++++
 tb/tb_conv_psum_store.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_psum_store_if.sv
// Handshake between the convolution stage (master) and the partial-sum store (slave).
interface conv_psum_store_if #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_W     = 8
);
    logic                 in_valid;
    logic [ACC_WIDTH-1:0] in_pixel;
    logic                 save_done;
    logic                 ch_done;
    logic [CNT_W-1:0]     pix_cnt;

    modport master (output in_valid, in_pixel, input save_done, ch_done, pix_cnt);
    modport slave  (input in_valid, in_pixel, output save_done, ch_done, pix_cnt);
endinterface

// File: rtl/conv_psum_store.sv
// Accumulates per-pixel partial sums across input channels and, on the last
// channel, writes the requantized 8-bit result into a readable output buffer.
module conv_psum_store #(
    parameter int DEPTH     = 256,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 8,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 layer,
    input  logic                 first_ch,
    input  logic                 last_ch,
    input  logic                 relu_out,
    conv_psum_store_if.slave     conv,
    input  logic [AW-1:0]        rd_addr,
    output logic [OUT_WIDTH-1:0] rd_data
);
    typedef enum logic [2:0] {IDLE, READ, ADD, ACK, DONE} state_t;

    localparam logic [AW-1:0] LAST_PIX0 = AW'(181);
    localparam logic [AW-1:0] LAST_PIX1 = AW'(131);
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << (SHIFT-1);

    state_t state, state_nxt;
    logic [AW-1:0] pix_cnt;
    logic save_done, ch_done, last_pix;

    logic [ACC_WIDTH-1:0] acc_ram [DEPTH];
    logic [OUT_WIDTH-1:0] out_ram [DEPTH];

    logic signed [ACC_WIDTH-1:0] pix_reg, ram_q, sum_sat, sat;
    logic signed [ACC_WIDTH:0]   addend, sum_ext, rnd, shr;
    logic [OUT_WIDTH-1:0]        q;

    assign last_pix = pix_cnt == (layer ? LAST_PIX1 : LAST_PIX0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pix_cnt <= '0;
            rd_data <= '0;
        end else if (clear) begin
            state   <= IDLE;
            pix_cnt <= '0;
            rd_data <= '0;
        end else begin
            state   <= state_nxt;
            rd_data <= out_ram[rd_addr];
            if (state == ACK)
                pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        save_done = 1'b0;
        ch_done   = 1'b0;
        case (state)
            IDLE: if (conv.in_valid) state_nxt = READ;
            READ: state_nxt = ADD;
            ADD:  state_nxt = ACK;
            ACK: begin
                save_done = 1'b1;
                ch_done   = last_pix;
                state_nxt = last_pix ? DONE : IDLE;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign conv.save_done = save_done;
    assign conv.ch_done   = ch_done;
    assign conv.pix_cnt   = pix_cnt;

    // Sum in one extra bit so overflow shows up as a sign-bit disagreement.
    always_comb begin
        addend  = first_ch ? '0 : {ram_q[ACC_WIDTH-1], ram_q};
        sum_ext = {pix_reg[ACC_WIDTH-1], pix_reg} + addend;
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])
            sat = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            sat = sum_ext[ACC_WIDTH-1:0];
    end

    // Round-half-up requantization; result fits when all bits above the
    // output sign bit replicate it.
    always_comb begin
        rnd = {sum_sat[ACC_WIDTH-1], sum_sat} + RND;
        shr = rnd >>> SHIFT;
        if (shr[ACC_WIDTH:OUT_WIDTH-1] == '0 || shr[ACC_WIDTH:OUT_WIDTH-1] == '1)
            q = shr[OUT_WIDTH-1:0];
        else if (shr[ACC_WIDTH])
            q = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            q = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        if (relu_out && q[OUT_WIDTH-1])
            q = '0;
    end

    // The accumulator is read every cycle; the value captured on the
    // IDLE->READ edge belongs to the current pixel since pix_cnt is stable.
    always_ff @(posedge clk) begin
        ram_q <= acc_ram[pix_cnt];
        if (state == IDLE && conv.in_valid)
            pix_reg <= conv.in_pixel;
        if (state == READ)
            sum_sat <= sat;
        if (state == ADD && !last_ch)
            acc_ram[pix_cnt] <= sum_sat;
        if (state == ADD && last_ch)
            out_ram[pix_cnt] <= q;
    end
endmodule

// File: tb/tb_conv_psum_store.sv
// Directed-plus-random bench for conv_psum_store with a conv-stage handshake
// model and an arithmetic reference of accumulation and requantization.
module tb_conv_psum_store;
    localparam int N0 = 182;
    localparam int N1 = 132;

    logic       clk = 1'b0;
    logic       rst, clear, layer, first_ch, last_ch, relu_out;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;

    conv_psum_store_if #(.ACC_WIDTH(24), .CNT_W(8)) conv ();

    conv_psum_store #(
        .DEPTH(256), .ACC_WIDTH(24), .OUT_WIDTH(8), .SHIFT(8)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .layer(layer),
        .first_ch(first_ch), .last_ch(last_ch), .relu_out(relu_out),
        .conv(conv), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int sd_cnt  = 0;
    int cd_cnt  = 0;

    logic signed [23:0] pix_vals [256];
    longint             acc_m    [256];
    logic [7:0]         out_m    [256];

    always @(negedge clk) begin
        if (conv.save_done) sd_cnt++;
        if (conv.ch_done)   cd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint sat24(input longint s);
        if (s > 64'sd8388607)  return 64'sd8388607;
        if (s < -64'sd8388608) return -64'sd8388608;
        return s;
    endfunction

    function automatic logic [7:0] requant(input longint s, input bit r);
        longint v;
        v = (s + 128) >>> 8;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        if (r && v < 0) v = 0;
        return v[7:0];
    endfunction

    function automatic logic signed [23:0] rnd_pix();
        case ($urandom_range(0, 3))
            0:       return 24'($urandom);
            1:       return 24'($urandom_range(0, 4000)) - 24'd2000;
            2:       return 24'h7FF000 + 24'($urandom_range(0, 4095));
            default: return 24'h800000 + 24'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) pix_vals[i] = rnd_pix();
    endtask

    // Conv-stage model: hold valid until save_done, drop it one cycle, reassert.
    task automatic feed(input int i, input int n);
        int cnt;
        cnt = 0;
        conv.in_valid = 1'b1;
        conv.in_pixel = pix_vals[i];
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!conv.save_done && cnt < 8);
        chk("latency", cnt, 3);
        chk("ch_done", 32'(conv.ch_done), 32'(i == n - 1));
        @(posedge clk); #1;
        conv.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input bit lyr, input bit f, input bit l, input bit r);
        int n, s0, c0;
        longint s;
        n = lyr ? N1 : N0;
        layer = lyr; first_ch = f; last_ch = l; relu_out = r;
        s0 = sd_cnt; c0 = cd_cnt;
        for (int i = 0; i < n; i++) feed(i, n);
        chk("pulse_count", sd_cnt - s0, n);
        chk("ch_done_count", cd_cnt - c0, 1);
        chk("pix_cnt_wrap", 32'(conv.pix_cnt), 0);
        for (int i = 0; i < n; i++) begin
            s = sat24(longint'(pix_vals[i]) + (f ? 64'sd0 : acc_m[i]));
            if (l) out_m[i] = requant(s, r);
            else   acc_m[i] = s;
        end
    endtask

    task automatic check_out(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 8'(i);
            @(posedge clk); #1;
            chk("rd_data", 32'(rd_data), 32'(out_m[i]));
        end
    endtask

    task automatic read_at(input int a, input logic [7:0] exp_v, input string tag);
        rd_addr = 8'(a);
        @(posedge clk); #1;
        chk(tag, 32'(rd_data), 32'(exp_v));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_pix_cnt", 32'(conv.pix_cnt), 0);
        chk("clear_save_done", 32'(conv.save_done), 0);
    endtask

    initial begin
        int s0;
        rst = 1'b1; clear = 1'b0; layer = 1'b0; first_ch = 1'b1; last_ch = 1'b1;
        relu_out = 1'b0; rd_addr = '0;
        conv.in_valid = 1'b0; conv.in_pixel = '0;
        #12;
        chk("rst_save_done", 32'(conv.save_done), 0);
        chk("rst_ch_done", 32'(conv.ch_done), 0);
        chk("rst_pix_cnt", 32'(conv.pix_cnt), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single pixel, single-channel layer
        layer = 1'b0; first_ch = 1'b1; last_ch = 1'b1; relu_out = 1'b1;
        pix_vals[0] = 24'sd1000;
        feed(0, N0);
        chk("single_pix_cnt", 32'(conv.pix_cnt), 1);
        read_at(0, 8'd4, "single_out");
        do_clear();

        // Two-channel accumulate on conv2
        for (int i = 0; i < N1; i++) pix_vals[i] = -24'sd300;
        run_pass(1'b1, 1'b1, 1'b0, 1'b0);
        s0 = sd_cnt;
        conv.in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("done_hold", sd_cnt - s0, 0);
        chk("done_pix_cnt", 32'(conv.pix_cnt), 0);
        conv.in_valid = 1'b0;
        do_clear();
        for (int i = 0; i < N1; i++) pix_vals[i] = 24'sd100;
        run_pass(1'b1, 1'b0, 1'b1, 1'b0);
        read_at(7, 8'hFF, "twoch_const");
        check_out(N1);
        do_clear();

        // Positive saturation of the accumulator and of the output
        fill_rand(); pix_vals[0] = 24'h7FFFF0;
        run_pass(1'b1, 1'b1, 1'b0, 1'b0);
        do_clear();
        fill_rand(); pix_vals[0] = 24'h000100;
        run_pass(1'b1, 1'b0, 1'b0, 1'b0);
        do_clear();
        fill_rand(); pix_vals[0] = 24'h000000;
        run_pass(1'b1, 1'b0, 1'b1, 1'b0);
        read_at(0, 8'd127, "sat_out");
        check_out(N1);
        do_clear();

        // ReLU clamp on conv1 with random remainder
        fill_rand(); pix_vals[0] = -24'sd5000;
        run_pass(1'b0, 1'b1, 1'b1, 1'b1);
        read_at(0, 8'd0, "relu_out");
        check_out(N0);
        do_clear();

        // Random three-channel accumulate on conv1
        fill_rand(); run_pass(1'b0, 1'b1, 1'b0, 1'b0); do_clear();
        fill_rand(); run_pass(1'b0, 1'b0, 1'b0, 1'b0); do_clear();
        fill_rand(); run_pass(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        check_out(N0);
        do_clear();

        // Asynchronous reset while in ADD
        layer = 1'b0; first_ch = 1'b1; last_ch = 1'b1; relu_out = 1'b0;
        fill_rand();
        for (int i = 0; i < 5; i++) feed(i, N0);
        conv.in_valid = 1'b1;
        conv.in_pixel = pix_vals[5];
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_save_done", 32'(conv.save_done), 0);
        chk("arst_ch_done", 32'(conv.ch_done), 0);
        chk("arst_pix_cnt", 32'(conv.pix_cnt), 0);
        conv.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        fill_rand();
        run_pass(1'b0, 1'b1, 1'b1, 1'b0);
        check_out(N0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
